// File: rtl/aes_pkg.sv
// Shared AES constants and types for the round-key datapath.
// The round-index type and the InvMixColumns round rule are shared by every stage.
package aes_pkg;

    localparam int NR_DEFAULT = 10;
    localparam int STATE_W    = 128;
    localparam int ROUND_W    = 4;

    typedef logic [ROUND_W-1:0] round_t;

    // Round NR (the initial add) and round 0 (the final add) both bypass InvMixColumns.
    function automatic logic needs_inv_mix(input round_t round, input round_t nr);
        return (round >= round_t'(1)) && (round < nr);
    endfunction

endpackage

// File: rtl/round_key_store.sv
// Round-key register file: NR+1 keys, per-index loaded flags, one write port
// and one combinational read port.
module round_key_store
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_we,
    input  round_t             key_waddr,
    input  logic [STATE_W-1:0] key_wdata,
    input  round_t             rd_round,
    output logic [STATE_W-1:0] rd_key,
    output logic               rd_loaded,
    output logic               keys_full
);

    localparam round_t NR_R = round_t'(NR);

    logic [STATE_W-1:0] r_keys [0:NR];
    logic [NR:0]        r_loaded;
    logic               w_wr_en;
    logic               w_rd_in_range;

    assign w_wr_en       = key_we && (key_waddr <= NR_R);
    assign w_rd_in_range = (rd_round <= NR_R);

    // Key contents are deliberately left unreset; the loaded flags alone qualify them.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_keys[key_waddr] <= key_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded <= '0;
        end else if (w_wr_en) begin
            r_loaded[key_waddr] <= 1'b1;
        end
    end

    // An out-of-range round reads as an all-zero key so the XOR passes the state through.
    assign rd_key    = w_rd_in_range ? r_keys[rd_round] : '0;
    assign rd_loaded = w_rd_in_range && r_loaded[rd_round];
    assign keys_full = &r_loaded;

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey pipeline stage for the inverse cipher: one registered XOR of the
// state with the selected round key, with a valid/ready handshake on both sides.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_we,
    input  logic [ROUND_W-1:0] key_waddr,
    input  logic [STATE_W-1:0] key_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [ROUND_W-1:0] in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_mix,
    output logic               keys_full,
    output logic               err_round
);

    localparam round_t NR_R = round_t'(NR);

    logic [STATE_W-1:0] w_key;
    logic               w_key_loaded;
    logic               w_round_oob;
    logic               w_xfer;

    logic               r_out_valid;
    logic [STATE_W-1:0] r_out_state;
    round_t             r_out_round;
    logic               r_out_mix;
    logic               r_err_round;

    round_key_store #(
        .NR(NR)
    ) u_key_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_waddr (key_waddr),
        .key_wdata (key_wdata),
        .rd_round  (in_round),
        .rd_key    (w_key),
        .rd_loaded (w_key_loaded),
        .keys_full (keys_full)
    );

    // Ready never looks at in_valid; an unloaded key for a legal round stalls the input.
    assign w_round_oob = (in_round > NR_R);
    assign in_ready    = (!r_out_valid || out_ready) && (w_round_oob || w_key_loaded);
    assign w_xfer      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_round <= '0;
            r_out_mix   <= 1'b0;
            r_err_round <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_state <= in_state ^ w_key;
                r_out_round <= in_round;
                r_out_mix   <= needs_inv_mix(in_round, NR_R);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && w_round_oob) begin
                r_err_round <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_round = r_out_round;
    assign out_mix   = r_out_mix;
    assign err_round = r_err_round;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage: directed FIPS-197 scenarios plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_add_round_key_stage;
    import aes_pkg::*;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rstN;
    logic         keyWe;
    logic [3:0]   keyWaddr;
    logic [127:0] keyWdata;
    logic         inValid;
    logic         inReady;
    logic [127:0] inState;
    logic [3:0]   inRound;
    logic         outValid;
    logic         outReady;
    logic [127:0] outState;
    logic [3:0]   outRound;
    logic         outMix;
    logic         keysFull;
    logic         errRound;

    always #5 clk = ~clk;

    add_round_key_stage #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .key_we    (keyWe),
        .key_waddr (keyWaddr),
        .key_wdata (keyWdata),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_state  (inState),
        .in_round  (inRound),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_state (outState),
        .out_round (outRound),
        .out_mix   (outMix),
        .keys_full (keysFull),
        .err_round (errRound)
    );

    // FIPS-197 AES-128 key schedule for cipher key 000102..0f
    logic [127:0] schedule [0:10];

    // Reference model: key table, loaded flags and the single result slot
    logic [127:0] mKeys   [0:15];
    bit           mLoaded [0:15];
    bit           mValid;
    logic [127:0] mState;
    logic [3:0]   mRound;
    bit           mMix;
    bit           mErr;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit modelReady();
        bit roundOk;
        roundOk = (int'(inRound) > NR) || mLoaded[inRound];
        return (!mValid || outReady) && roundOk;
    endfunction

    function automatic bit modelFull();
        bit full = 1'b1;
        for (int i = 0; i <= NR; i++) full &= mLoaded[i];
        return full;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mLoaded[i] = 1'b0;
        mValid = 1'b0;
        mState = '0;
        mRound = '0;
        mMix   = 1'b0;
        mErr   = 1'b0;
    endtask

    // One clock: compare everything before the edge, then advance the model past it.
    task automatic applyStimulus();
        bit           rdy;
        bit           nValid;
        logic [127:0] nState;
        logic [3:0]   nRound;
        bit           nMix;
        bit           nErr;
        @(negedge clk);
        rdy = modelReady();
        checkOutput("inReady", 128'(inReady), 128'(rdy));
        checkOutput("outValid", 128'(outValid), 128'(mValid));
        checkOutput("keysFull", 128'(keysFull), 128'(modelFull()));
        checkOutput("errRound", 128'(errRound), 128'(mErr));
        if (mValid) begin
            checkOutput("outState", outState, mState);
            checkOutput("outRound", 128'(outRound), 128'(mRound));
            checkOutput("outMix", 128'(outMix), 128'(mMix));
        end
        nValid = mValid;
        nState = mState;
        nRound = mRound;
        nMix   = mMix;
        nErr   = mErr;
        if (inValid && rdy) begin
            nValid = 1'b1;
            nState = (int'(inRound) <= NR) ? (inState ^ mKeys[inRound]) : inState;
            nRound = inRound;
            nMix   = (int'(inRound) >= 1) && (int'(inRound) <= NR - 1);
            if (int'(inRound) > NR) nErr = 1'b1;
        end else if (outReady) begin
            nValid = 1'b0;
        end
        @(posedge clk);
        #1;
        mValid = nValid;
        mState = nState;
        mRound = nRound;
        mMix   = nMix;
        mErr   = nErr;
        if (keyWe && int'(keyWaddr) <= NR) begin
            mKeys[keyWaddr]   = keyWdata;
            mLoaded[keyWaddr] = 1'b1;
        end
    endtask

    task automatic randomInputs(input bit allowKeyWrites);
        inValid  = 1'($urandom_range(0, 1));
        outReady = ($urandom_range(0, 3) != 0);
        inRound  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        inState  = {$urandom, $urandom, $urandom, $urandom};
        keyWe    = allowKeyWrites && ($urandom_range(0, 3) == 0);
        keyWaddr = 4'($urandom_range(0, 15));
        keyWdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [127:0] stateA;
        logic [127:0] stateB;
        logic [127:0] newKey5;
        logic [127:0] oldKey5;
        logic [3:0]   b2bRounds [0:2];

        schedule[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        schedule[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        schedule[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        schedule[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        schedule[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        schedule[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        schedule[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        schedule[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        schedule[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        schedule[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        schedule[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 0; i < 16; i++) mKeys[i] = '0;
        modelReset();

        rstN     = 1'b0;
        keyWe    = 1'b0;
        keyWaddr = '0;
        keyWdata = '0;
        inValid  = 1'b0;
        inState  = '0;
        inRound  = '0;
        outReady = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.outValid", 128'(outValid), 128'd0);
        checkOutput("reset.outState", outState, 128'd0);
        checkOutput("reset.outRound", 128'(outRound), 128'd0);
        checkOutput("reset.outMix", 128'(outMix), 128'd0);
        checkOutput("reset.keysFull", 128'(keysFull), 128'd0);
        checkOutput("reset.errRound", 128'(errRound), 128'd0);
        rstN = 1'b1;

        // Load keys 0..9 only, then hold a round-10 state valid: it must stall.
        for (int i = 0; i <= 9; i++) begin
            keyWe    = 1'b1;
            keyWaddr = 4'(i);
            keyWdata = schedule[i];
            applyStimulus();
        end
        keyWe   = 1'b0;
        inValid = 1'b1;
        inRound = 4'd10;
        inState = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        repeat (3) begin
            applyStimulus();
            checkOutput("stall.inReady", 128'(inReady), 128'd0);
            checkOutput("stall.outValid", 128'(outValid), 128'd0);
        end
        keyWe    = 1'b1;
        keyWaddr = 4'd10;
        keyWdata = schedule[10];
        applyStimulus();
        keyWe = 1'b0;
        checkOutput("loaded.inReady", 128'(inReady), 128'd1);
        checkOutput("loaded.keysFull", 128'(keysFull), 128'd1);
        applyStimulus();
        inValid = 1'b0;
        checkOutput("fips.outValid", 128'(outValid), 128'd1);
        checkOutput("fips.outState", outState, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        checkOutput("fips.outMix", 128'(outMix), 128'd0);
        checkOutput("fips.outRound", 128'(outRound), 128'd10);

        // Back-to-back rounds 9,8,7, then a two-cycle downstream stall.
        b2bRounds[0] = 4'd9;
        b2bRounds[1] = 4'd8;
        b2bRounds[2] = 4'd7;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inRound = b2bRounds[i];
            inState = {$urandom, $urandom, $urandom, $urandom};
            stateA  = inState;
            applyStimulus();
            checkOutput("b2b.outValid", 128'(outValid), 128'd1);
            checkOutput("b2b.outMix", 128'(outMix), 128'd1);
            checkOutput("b2b.outState", outState, stateA ^ schedule[b2bRounds[i]]);
        end
        outReady = 1'b0;
        inRound  = 4'd6;
        inState  = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) begin
            applyStimulus();
            checkOutput("frozen.inReady", 128'(inReady), 128'd0);
            checkOutput("frozen.outRound", 128'(outRound), 128'd7);
            checkOutput("frozen.outState", outState, stateA ^ schedule[7]);
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        applyStimulus();

        // Same-cycle rewrite of key 5 must not affect the transfer that reads it.
        oldKey5  = schedule[5];
        newKey5  = {$urandom, $urandom, $urandom, $urandom};
        stateA   = {$urandom, $urandom, $urandom, $urandom};
        stateB   = {$urandom, $urandom, $urandom, $urandom};
        inValid  = 1'b1;
        inRound  = 4'd5;
        inState  = stateA;
        keyWe    = 1'b1;
        keyWaddr = 4'd5;
        keyWdata = newKey5;
        applyStimulus();
        keyWe = 1'b0;
        checkOutput("oldKey.outState", outState, stateA ^ oldKey5);
        inState = stateB;
        applyStimulus();
        checkOutput("newKey.outState", outState, stateB ^ newKey5);
        inValid = 1'b0;
        applyStimulus();

        // Out-of-range round passes through and latches the error flag.
        stateA  = {$urandom, $urandom, $urandom, $urandom};
        inValid = 1'b1;
        inRound = 4'd12;
        inState = stateA;
        applyStimulus();
        inValid = 1'b0;
        checkOutput("oob.outState", outState, stateA);
        checkOutput("oob.outMix", 128'(outMix), 128'd0);
        checkOutput("oob.errRound", 128'(errRound), 128'd1);
        repeat (3) applyStimulus();
        checkOutput("oob.errSticky", 128'(errRound), 128'd1);

        // Random traffic with all keys loaded and occasional key rewrites.
        repeat (200) begin
            randomInputs(1'b1);
            applyStimulus();
        end

        // Asynchronous reset while a result is held.
        keyWe    = 1'b0;
        outReady = 1'b0;
        inValid  = 1'b1;
        inRound  = 4'd3;
        applyStimulus();
        checkOutput("preRst.outValid", 128'(outValid), 128'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRst.outValid", 128'(outValid), 128'd0);
        checkOutput("asyncRst.keysFull", 128'(keysFull), 128'd0);
        checkOutput("asyncRst.errRound", 128'(errRound), 128'd0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("postRst.inReady", 128'(inReady), 128'd0);

        // Random traffic from an empty key store: legal rounds stall until loaded.
        repeat (300) begin
            randomInputs(1'b1);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
